// File: rtl/lsu_mem_master_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_master_if
// Description : Request/response handshake and data-memory port bundle for
//               the load/store requester.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_master_if #(
  parameter int ADDRESS_SIZE = 10,
  parameter int N            = 64
);
  // core-side request
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [2:0]              req_funct3;
  logic [ADDRESS_SIZE+2:0] req_addr;
  logic [N-1:0]            req_wdata;
  // core-side response
  logic                    rsp_valid;
  logic [N-1:0]            rsp_rdata;
  logic                    rsp_err;
  // data-memory port
  logic                    mem_read;
  logic                    mem_write;
  logic [ADDRESS_SIZE-1:0] mem_rd_addr;
  logic [ADDRESS_SIZE-1:0] mem_wr_addr;
  logic [N-1:0]            mem_wdata;
  logic [N-1:0]            mem_rdata;

  // the load/store unit side
  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_read, mem_write, mem_rd_addr, mem_wr_addr, mem_wdata
  );

  // the core plus memory side
  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_read, mem_write, mem_rd_addr, mem_wr_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_master
// Description : One-at-a-time RISC-V load/store requester for a single-cycle
//               64-bit data memory. Checks alignment, performs read-modify-
//               write for sub-doubleword stores and returns extended load
//               data (or an error) on a one-cycle response strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_master #(
  parameter int ADDRESS_SIZE = 10,
  parameter int N            = 64
) (
  input  wire logic       clk,
  input  wire logic       rst,   // asynchronous, active low
  lsu_mem_master_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]              r_state;
  logic [2:0]              w_next;
  logic                    r_we;
  logic [2:0]              r_funct3;
  logic [ADDRESS_SIZE-1:0] r_idx;
  logic [2:0]              r_off;
  logic [N-1:0]            r_wdata;
  logic [N-1:0]            r_rbuf;
  logic [N-1:0]            r_rdata;

  logic                    w_illegal;
  logic                    w_misalign;
  logic                    w_bad;
  logic [N-1:0]            w_rsh;
  logic [N-1:0]            w_load_ext;
  logic [7:0]              w_base_mask;
  logic [7:0]              w_lane_mask;
  logic [N-1:0]            w_wsh;
  logic [N-1:0]            w_merge;

  // Classify the incoming request: illegal funct3 or a misaligned offset
  always_comb begin
    w_illegal = (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);
    case (bus.req_funct3[1:0])
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = bus.req_addr[0];
      2'd2:    w_misalign = |bus.req_addr[1:0];
      default: w_misalign = |bus.req_addr[2:0];
    endcase
    w_bad = w_illegal || w_misalign;
  end

  // Select the addressed lane of the memory word and extend it per funct3
  always_comb begin
    w_rsh = bus.mem_rdata >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_load_ext = {{(N-8){w_rsh[7]}},   w_rsh[7:0]};
      3'b001:  w_load_ext = {{(N-16){w_rsh[15]}}, w_rsh[15:0]};
      3'b010:  w_load_ext = {{(N-32){w_rsh[31]}}, w_rsh[31:0]};
      3'b011:  w_load_ext = w_rsh;
      3'b100:  w_load_ext = {{(N-8){1'b0}},  w_rsh[7:0]};
      3'b101:  w_load_ext = {{(N-16){1'b0}}, w_rsh[15:0]};
      3'b110:  w_load_ext = {{(N-32){1'b0}}, w_rsh[31:0]};
      default: w_load_ext = '0;
    endcase
  end

  // Merge the store bytes into the buffered word; a doubleword covers all lanes
  always_comb begin
    case (r_funct3[1:0])
      2'd0:    w_base_mask = 8'h01;
      2'd1:    w_base_mask = 8'h03;
      2'd2:    w_base_mask = 8'h0F;
      default: w_base_mask = 8'hFF;
    endcase
    w_lane_mask = w_base_mask << r_off;
    w_wsh       = r_wdata << {r_off, 3'b000};
    w_merge     = r_rbuf;
    for (int i = 0; i < 8; i++) begin
      if (w_lane_mask[i]) begin
        w_merge[8*i +: 8] = w_wsh[8*i +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        w_next = S_IDLE;
        if (bus.req_valid) begin
          if (w_bad)                                   w_next = S_ERR;
          else if (bus.req_we && bus.req_funct3 == 3'b011) w_next = S_WR;
          else                                         w_next = S_RD;
        end
      end
      S_RD:    w_next = r_we ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, read buffer and registered response data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_idx    <= '0;
      r_off    <= 3'b000;
      r_wdata  <= '0;
      r_rbuf   <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_idx    <= bus.req_addr[ADDRESS_SIZE+2:3];
            r_off    <= bus.req_addr[2:0];
            r_wdata  <= bus.req_wdata;
            if (w_bad) r_rdata <= '0;
          end
        end
        S_RD: begin
          r_rbuf <= bus.mem_rdata;
          if (!r_we) r_rdata <= w_load_ext;
        end
        S_WR:    r_rdata <= '0;
        default: ;
      endcase
    end
  end

  // Output decode: strobes only in RD/WR, addresses hold the latched index
  always_comb begin
    bus.req_ready   = (r_state == S_IDLE);
    bus.mem_read    = (r_state == S_RD);
    bus.mem_write   = (r_state == S_WR);
    bus.mem_rd_addr = r_idx;
    bus.mem_wr_addr = r_idx;
    bus.mem_wdata   = (r_state == S_WR) ? w_merge : '0;
    bus.rsp_valid   = (r_state == S_RESP) || (r_state == S_ERR);
    bus.rsp_err     = (r_state == S_ERR);
    bus.rsp_rdata   = r_rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_master
// Description : Directed self-checking bench for lsu_mem_master with a
//               behavioural single-cycle 64-bit data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_master;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lsu_mem_master_if #(.ADDRESS_SIZE(AW), .N(64)) bus ();
  lsu_mem_master #(.ADDRESS_SIZE(AW), .N(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [63:0] mem [0:(1<<AW)-1];
  assign bus.mem_rdata = mem[bus.mem_rd_addr];

  int          rd_cnt = 0, wr_cnt = 0, rsp_cnt = 0, both_cnt = 0, wd_cnt = 0;
  logic [AW-1:0] last_rd = '0, last_wr = '0;
  logic [63:0] last_wdata = '0;

  // memory write port plus strobe monitor
  always @(posedge clk) begin
    if (bus.mem_read) begin rd_cnt++; last_rd = bus.mem_rd_addr; end
    if (bus.mem_write) begin
      wr_cnt++; last_wr = bus.mem_wr_addr; last_wdata = bus.mem_wdata;
      mem[bus.mem_wr_addr] = bus.mem_wdata;
    end
    if (bus.mem_read && bus.mem_write) both_cnt++;
    if (!bus.mem_write && bus.mem_wdata != 64'd0) wd_cnt++;
    if (bus.rsp_valid) rsp_cnt++;
  end

  // Issue one request and observe it up to one cycle past its response
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [AW+2:0] addr,
                        input logic [63:0] wd, output int lat, output logic [63:0] rdata,
                        output logic err, output int drd, output int dwr,
                        output int rdy_low, output logic rdy_after);
    int rd0, wr0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    lat = 0; rdy_low = 0; rdata = 'x; err = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      if (!bus.req_ready) rdy_low++;
      if (bus.rsp_valid) begin
        lat = i; rdata = bus.rsp_rdata; err = bus.rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rdy_after = bus.req_ready;
    drd = rd_cnt - rd0;
    dwr = wr_cnt - wr0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.rsp_valid, bus.rsp_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got=%b exp=0000", {bus.mem_read, bus.mem_write, bus.rsp_valid, bus.rsp_err});
    end
    checks++;
    if ({bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wdata, bus.rsp_rdata} !== '0) begin
      errors++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wdata, bus.rsp_rdata);
    end
    rst = 1'b1;
  endtask

  task automatic test_loads();
    int lat, drd, dwr, rl; logic [63:0] rd; logic err, ra;
    logic [2:0]  f3s  [3] = '{3'b101, 3'b010, 3'b011};
    logic [12:0] adrs [3] = '{13'h02E, 13'h028, 13'h028};
    logic [63:0] exps [3] = '{64'h0000_0000_0000_8877, 64'h0000_0000_4433_2211, 64'h8877_6655_4433_2211};
    do_req(1'b0, 3'b000, 13'h02F, 64'd0, lat, rd, err, drd, dwr, rl, ra);
    checks++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FF88 || err !== 1'b0) begin
      errors++; $display("FAIL lb_data got=%h err=%b exp=ffffffffffffff88 err=0", rd, err);
    end
    checks++;
    if (lat !== 2 || drd !== 1 || dwr !== 0 || last_rd !== 10'd5) begin
      errors++; $display("FAIL lb_timing got lat=%0d rd=%0d wr=%0d addr=%0d exp 2/1/0/5", lat, drd, dwr, last_rd);
    end
    checks++;
    if (bus.rsp_rdata !== 64'hFFFF_FFFF_FFFF_FF88 || ra !== 1'b1) begin
      errors++; $display("FAIL lb_hold got=%h ready=%b exp=ffffffffffffff88 ready=1", bus.rsp_rdata, ra);
    end
    for (int k = 0; k < 3; k++) begin
      do_req(1'b0, f3s[k], adrs[k], 64'd0, lat, rd, err, drd, dwr, rl, ra);
      checks++;
      if (rd !== exps[k] || lat !== 2 || err !== 1'b0 || drd !== 1) begin
        errors++; $display("FAIL load%0d got=%h lat=%0d err=%b rd=%0d exp=%h lat=2 err=0 rd=1", k, rd, lat, err, drd, exps[k]);
      end
    end
  endtask

  task automatic test_store_byte();
    int lat, drd, dwr, rl; logic [63:0] rd; logic err, ra;
    do_req(1'b1, 3'b000, 13'h029, 64'hFFFF_FFFF_FFFF_FFAB, lat, rd, err, drd, dwr, rl, ra);
    checks++;
    if (last_wdata !== 64'h8877_6655_4433_AB11 || last_wr !== 10'd5) begin
      errors++; $display("FAIL sb_wdata got=%h addr=%0d exp=887766554433ab11 addr=5", last_wdata, last_wr);
    end
    checks++;
    if (lat !== 3 || drd !== 1 || dwr !== 1 || last_rd !== 10'd5 || rd !== 64'd0 || err !== 1'b0) begin
      errors++; $display("FAIL sb_timing got lat=%0d rd=%0d wr=%0d data=%h err=%b exp 3/1/1/0/0", lat, drd, dwr, rd, err);
    end
  endtask

  task automatic test_store_double();
    int lat, drd, dwr, rl; logic [63:0] rd; logic err, ra;
    do_req(1'b1, 3'b011, 13'h030, 64'h0123_4567_89AB_CDEF, lat, rd, err, drd, dwr, rl, ra);
    checks++;
    if (lat !== 2 || drd !== 0 || dwr !== 1 || last_wr !== 10'd6 || last_wdata !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL sd got lat=%0d rd=%0d wr=%0d addr=%0d data=%h exp 2/0/1/6/0123456789abcdef", lat, drd, dwr, last_wr, last_wdata);
    end
    do_req(1'b0, 3'b011, 13'h030, 64'd0, lat, rd, err, drd, dwr, rl, ra);
    checks++;
    if (rd !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL sd_readback got=%h exp=0123456789abcdef", rd);
    end
  endtask

  task automatic test_errors();
    int lat, drd, dwr, rl; logic [63:0] rd; logic err, ra;
    logic        wes  [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s  [3] = '{3'b010, 3'b100, 3'b111};
    logic [12:0] adrs [3] = '{13'h02A, 13'h029, 13'h028};
    for (int k = 0; k < 3; k++) begin
      do_req(wes[k], f3s[k], adrs[k], 64'hFFFF_FFFF_FFFF_FFFF, lat, rd, err, drd, dwr, rl, ra);
      checks++;
      if (err !== 1'b1 || lat !== 1 || rd !== 64'd0) begin
        errors++; $display("FAIL err%0d got err=%b lat=%0d data=%h exp err=1 lat=1 data=0", k, err, lat, rd);
      end
      checks++;
      if (drd !== 0 || dwr !== 0 || rl !== 1 || ra !== 1'b1) begin
        errors++; $display("FAIL err%0d_strobes got rd=%0d wr=%0d busy=%0d ready=%b exp 0/0/1/1", k, drd, dwr, rl, ra);
      end
    end
  endtask

  task automatic test_mid_reset();
    int lat, drd, dwr, rl, wr0, rsp0; logic [63:0] rd; logic err, ra;
    wr0 = wr_cnt; rsp0 = rsp_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001;
    bus.req_addr = 13'h02A; bus.req_wdata = 64'h1234;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL midrst_in_rd got=%b exp=1", bus.mem_read); end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.mem_read, bus.mem_write, bus.rsp_valid, bus.rsp_err} !== 5'b10000 ||
        {bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wdata, bus.rsp_rdata} !== '0) begin
      errors++; $display("FAIL midrst_outputs got ctl=%b rdaddr=%0d rdata=%h exp ctl=10000 all zero",
                         {bus.req_ready, bus.mem_read, bus.mem_write, bus.rsp_valid, bus.rsp_err}, bus.mem_rd_addr, bus.rsp_rdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt !== wr0 || rsp_cnt !== rsp0 || mem[5] !== 64'h8877_6655_4433_AB11) begin
      errors++; $display("FAIL midrst_aborted got writes=%0d rsps=%0d word5=%h exp 0/0/887766554433ab11", wr_cnt - wr0, rsp_cnt - rsp0, mem[5]);
    end
    do_req(1'b0, 3'b011, 13'h028, 64'd0, lat, rd, err, drd, dwr, rl, ra);
    checks++;
    if (rd !== 64'h8877_6655_4433_AB11 || lat !== 2 || err !== 1'b0) begin
      errors++; $display("FAIL midrst_next got=%h lat=%0d err=%b exp=887766554433ab11 lat=2 err=0", rd, lat, err);
    end
  endtask

  task automatic test_boundary();
    int lat, drd, dwr, rl; logic [63:0] rd; logic err, ra;
    do_req(1'b0, 3'b000, 13'h1FFF, 64'd0, lat, rd, err, drd, dwr, rl, ra);
    checks++;
    if (rd !== 64'h0000_0000_0000_007F || last_rd !== 10'd1023 || err !== 1'b0) begin
      errors++; $display("FAIL top_byte got=%h addr=%0d err=%b exp=7f addr=1023 err=0", rd, last_rd, err);
    end
    do_req(1'b1, 3'b001, 13'h02C, 64'h0000_0000_0000_BEEF, lat, rd, err, drd, dwr, rl, ra);
    checks++;
    if (last_wdata !== 64'h8877_BEEF_4433_AB11 || lat !== 3) begin
      errors++; $display("FAIL sh_merge got=%h lat=%0d exp=8877beef4433ab11 lat=3", last_wdata, lat);
    end
    do_req(1'b0, 3'b001, 13'h02C, 64'd0, lat, rd, err, drd, dwr, rl, ra);
    checks++;
    if (rd !== 64'hFFFF_FFFF_FFFF_BEEF) begin
      errors++; $display("FAIL lh_sext got=%h exp=ffffffffffffbeef", rd);
    end
  endtask

  task automatic test_strobe_rules();
    checks++;
    if (both_cnt !== 0 || wd_cnt !== 0) begin
      errors++; $display("FAIL strobe_rules got both=%0d wdata_outside_wr=%0d exp 0/0", both_cnt, wd_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 64'd0;
    mem[5]    = 64'h8877_6655_4433_2211;
    mem[1023] = 64'h7F00_0000_0000_0000;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_loads();
    test_store_byte();
    test_store_double();
    test_errors();
    test_mid_reset();
    test_boundary();
    test_strobe_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
